stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arbiter.sv | 120 ++++++++++++
 tb/tb_stack_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Two-requester LIFO stack with round-robin arbitration of push/pop operations.
// Latency: one edge; grant, count, dout, dout_valid and err are registered.
// Backpressure: a requester is ignored in the cycle after its own grant; illegal ops are granted and flagged with err.
module stack_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     op0,
  input  logic                     op1,
  input  logic [WIDTH-1:0]         din0,
  input  logic [WIDTH-1:0]         din1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     err,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Stack storage; deliberately not reset, only entries below count are ever read.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [CW-1:0]    r_count;
  logic             r_gnt0;
  logic             r_gnt1;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_err;
  logic             r_last_gnt;
  // Goes high on the first edge after reset release; ops seen on that edge are dropped.
  logic             r_arm;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_any;
  logic             w_win1;
  logic             w_op;
  logic [WIDTH-1:0] w_din;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_illegal;
  logic [AW-1:0]    w_push_idx;
  logic [AW-1:0]    w_pop_idx;

  // Arbitration: a held request is masked while its grant pulse is high, ties go to the
  // requester that was not granted last, then the winner's op is qualified against count.
  always_comb begin
    w_elig0    = req0 & ~r_gnt0 & r_arm;
    w_elig1    = req1 & ~r_gnt1 & r_arm;
    w_any      = w_elig0 | w_elig1;
    w_win1     = w_elig1 & (~w_elig0 | ~r_last_gnt);
    w_op       = w_win1 ? op1 : op0;
    w_din      = w_win1 ? din1 : din0;
    w_full     = (r_count == CW'(DEPTH));
    w_empty    = (r_count == '0);
    w_push_ok  = w_any & w_op & ~w_full;
    w_pop_ok   = w_any & ~w_op & ~w_empty;
    w_illegal  = w_any & ~(w_push_ok | w_pop_ok);
    // When count==DEPTH the low bits wrap to 0, so the pop index still lands on DEPTH-1.
    w_push_idx = r_count[AW-1:0];
    w_pop_idx  = w_push_idx - AW'(1);
  end

  // Control and output registers: execute at most one operation per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm        <= 1'b0;
      r_count      <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
      r_last_gnt   <= 1'b1;
    end else begin
      r_arm        <= 1'b1;
      r_gnt0       <= w_any & ~w_win1;
      r_gnt1       <= w_any & w_win1;
      r_dout_valid <= w_pop_ok;
      r_err        <= w_illegal;
      if (w_any) begin
        r_last_gnt <= w_win1;
      end
      if (w_push_ok) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_ok) begin
        r_count <= r_count - CW'(1);
        r_dout  <= r_mem[w_pop_idx];
      end
    end
  end

  // Memory write on a legal push only.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_push_idx] <= w_din;
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign err        = r_err;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: vector table plus hand-written reset/contention sequences.
// Inputs change 1 time unit after each rising edge; outputs are checked at that point.
// Expected values are hand-computed from the behavioural description of the stack.
module tb_stack_arbiter;

  localparam int W = 4;
  localparam int D = 4;
  localparam logic PUSH = 1'b1;
  localparam logic POP  = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [W-1:0] din0 = '0, din1 = '0;
  logic         gnt0, gnt1, dout_valid, err, full, empty;
  logic [W-1:0] dout;
  logic [2:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .dout(dout), .dout_valid(dout_valid),
    .err(err), .full(full), .empty(empty), .count(count)
  );

  typedef struct {
    logic         r0, o0;
    logic [W-1:0] d0;
    logic         r1, o1;
    logic [W-1:0] d1;
    logic         g0, g1;
    logic [W-1:0] dq;
    logic         dv, er;
    logic [2:0]   cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic r0, input logic o0, input logic [W-1:0] d0,
                      input logic r1, input logic o1, input logic [W-1:0] d1,
                      input logic g0, input logic g1, input logic [W-1:0] dq,
                      input logic dv, input logic er, input logic [2:0] cnt);
    vec_t v;
    v.r0 = r0; v.o0 = o0; v.d0 = d0; v.r1 = r1; v.o1 = o1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.dq = dq; v.dv = dv; v.er = er; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic o0, input logic [W-1:0] d0,
                       input logic r1, input logic o1, input logic [W-1:0] d1);
    req0 = r0; op0 = o0; din0 = d0;
    req1 = r1; op1 = o1; din1 = d1;
  endtask

  task automatic chk_all(input string tag, input logic g0, input logic g1,
                         input logic [W-1:0] dq, input logic dv, input logic er,
                         input logic [2:0] cnt);
    chk({tag, " gnt0"}, 32'(gnt0), 32'(g0));
    chk({tag, " gnt1"}, 32'(gnt1), 32'(g1));
    chk({tag, " dout"}, 32'(dout), 32'(dq));
    chk({tag, " dout_valid"}, 32'(dout_valid), 32'(dv));
    chk({tag, " err"}, 32'(err), 32'(er));
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " full"}, 32'(full), 32'(cnt == 3'(D)));
    chk({tag, " empty"}, 32'(empty), 32'(cnt == 3'd0));
  endtask

  initial begin
    logic exp_g0 [6];
    logic exp_er [6];
    logic [2:0] exp_cnt [6];

    // Table: inputs (r0,o0,d0, r1,o1,d1) then expected (g0,g1,dout,dv,err,count).
    addv(1, PUSH, 4'hA, 0, POP,  4'h0, 1, 0, 4'h0, 0, 0, 3'd1);
    addv(0, POP,  4'h0, 0, POP,  4'h0, 0, 0, 4'h0, 0, 0, 3'd1);
    addv(1, PUSH, 4'h5, 0, POP,  4'h0, 1, 0, 4'h0, 0, 0, 3'd2);
    addv(0, POP,  4'h0, 1, POP,  4'h0, 0, 1, 4'h5, 1, 0, 3'd1);
    addv(0, POP,  4'h0, 0, POP,  4'h0, 0, 0, 4'h5, 0, 0, 3'd1);
    addv(0, POP,  4'h0, 1, POP,  4'h0, 0, 1, 4'hA, 1, 0, 3'd0);
    addv(0, POP,  4'h0, 0, POP,  4'h0, 0, 0, 4'hA, 0, 0, 3'd0);
    addv(1, POP,  4'h0, 0, POP,  4'h0, 1, 0, 4'hA, 0, 1, 3'd0);
    addv(0, POP,  4'h0, 1, PUSH, 4'h1, 0, 1, 4'hA, 0, 0, 3'd1);
    addv(1, PUSH, 4'h2, 0, POP,  4'h0, 1, 0, 4'hA, 0, 0, 3'd2);
    addv(0, POP,  4'h0, 1, PUSH, 4'h3, 0, 1, 4'hA, 0, 0, 3'd3);
    addv(1, PUSH, 4'h4, 0, POP,  4'h0, 1, 0, 4'hA, 0, 0, 3'd4);
    addv(0, POP,  4'h0, 1, PUSH, 4'hF, 0, 1, 4'hA, 0, 1, 3'd4);
    addv(1, POP,  4'h0, 0, POP,  4'h0, 1, 0, 4'h4, 1, 0, 3'd3);
    addv(0, POP,  4'h0, 0, POP,  4'h0, 0, 0, 4'h4, 0, 0, 3'd3);
    addv(0, POP,  4'h0, 1, POP,  4'h0, 0, 1, 4'h3, 1, 0, 3'd2);
    addv(1, POP,  4'h0, 0, POP,  4'h0, 1, 0, 4'h2, 1, 0, 3'd1);
    addv(0, POP,  4'h0, 1, POP,  4'h0, 0, 1, 4'h1, 1, 0, 3'd0);
    addv(0, POP,  4'h0, 0, POP,  4'h0, 0, 0, 4'h1, 0, 0, 3'd0);
    addv(1, PUSH, 4'h7, 1, PUSH, 4'h8, 1, 0, 4'h1, 0, 0, 3'd1);
    addv(1, PUSH, 4'h7, 1, PUSH, 4'h8, 0, 1, 4'h1, 0, 0, 3'd2);
    addv(1, PUSH, 4'h7, 1, PUSH, 4'h8, 1, 0, 4'h1, 0, 0, 3'd3);
    addv(1, PUSH, 4'h7, 1, PUSH, 4'h8, 0, 1, 4'h1, 0, 0, 3'd4);
    addv(1, PUSH, 4'h7, 1, PUSH, 4'h8, 1, 0, 4'h1, 0, 1, 3'd4);
    addv(0, POP,  4'h0, 0, POP,  4'h0, 0, 0, 4'h1, 0, 0, 3'd4);
    addv(0, POP,  4'h0, 1, POP,  4'h0, 0, 1, 4'h8, 1, 0, 3'd3);
    addv(1, POP,  4'h0, 1, POP,  4'h0, 1, 0, 4'h7, 1, 0, 3'd2);
    addv(0, POP,  4'h0, 0, POP,  4'h0, 0, 0, 4'h7, 0, 0, 3'd2);

    // Reset state, checked while reset is held and before any clock edge.
    #1;
    chk_all("reset", 0, 0, 4'h0, 0, 0, 3'd0);
    step();
    step();
    rst_n = 1'b1;
    // First edge after release only arms the block.
    step();
    chk_all("arm", 0, 0, 4'h0, 0, 0, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r0, tbl[i].o0, tbl[i].d0, tbl[i].r1, tbl[i].o1, tbl[i].d1);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].dq,
              tbl[i].dv, tbl[i].er, tbl[i].cnt);
    end

    // Reset while a grant pulse is high: outputs clear without waiting for a clock.
    drive(1, PUSH, 4'h9, 0, POP, 4'h0);
    step();
    chk("pre-reset gnt0", 32'(gnt0), 32'd1);
    chk("pre-reset count", 32'(count), 32'd3);
    drive(1, PUSH, 4'h3, 1, PUSH, 4'h6);
    rst_n = 1'b0;
    #1;
    chk_all("async-reset", 0, 0, 4'h0, 0, 0, 3'd0);
    step();
    rst_n = 1'b1;
    // Both requests already present on the release edge must be ignored.
    step();
    chk_all("release-edge", 0, 0, 4'h0, 0, 0, 3'd0);

    // Continuous contention: requester 0 first, then strict alternation, overflow flagged.
    exp_g0  = '{1, 0, 1, 0, 1, 0};
    exp_er  = '{0, 0, 0, 0, 1, 1};
    exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    for (int e = 0; e < 6; e++) begin
      step();
      chk_all($sformatf("contend%0d", e), exp_g0[e], !exp_g0[e], 4'h0, 0,
              exp_er[e], exp_cnt[e]);
    end

    // The last legal push came from requester 1 (0x6), so it is the top of stack.
    drive(1, POP, 4'h0, 0, POP, 4'h0);
    step();
    chk_all("lifo-pop", 1, 0, 4'h6, 1, 0, 3'd3);
    drive(0, POP, 4'h0, 0, POP, 4'h0);
    step();
    chk_all("hold", 0, 0, 4'h6, 0, 0, 3'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
